// File: rtl/spi_config_assembler_pkg.sv
// Shared definitions for the SPI configuration assembler.
//   state_t        : frame FSM states
//   ERR_*          : error-cause codes reported on last_error
//   HEADER_DEFAULT : required first byte of every frame
//   FRAME_BYTES    : number of payload bytes per frame
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_ABT  = 2'd3;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_BYTES    = 4;
  localparam int unsigned IDX_W          = $clog2(FRAME_BYTES);

endpackage

// File: rtl/spi_config_assembler_timeout.sv
// Inter-byte timeout counter for an in-progress frame.
//   clk, rst_n : clock, async active-low reset
//   run        : a frame is in progress (counter idles at 0 otherwise)
//   kick       : byte accepted this cycle; restarts the count
//   expired    : TIMEOUT_CYCLES-1 cycles elapsed with no byte, and none this cycle
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  logic [TCW-1:0] timer_q;
  logic [TCW-1:0] timer_d;

  assign expired = run && !kick && (timer_q == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = timer_q + TCW'(1);
    if (!run || kick || expired) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

endmodule

// File: rtl/spi_config_assembler.sv
// Assembles framed, checksummed SPI bytes into the VGA configuration word.
// Frame: HEADER, D3, D2, D1, D0, CHK where CHK = D3^D2^D1^D0.
//   clk, rst_n    : clock, async active-low reset
//   ss_n          : synchronised chip select (high aborts an in-progress frame)
//   byte_data/_valid : received byte and its one-cycle strobe
//   err_clear     : clears error_count
//   config_out    : live configuration word; config_update pulses on commit
//   busy          : FSM not IDLE (combinational)
//   error_count   : saturating frame error count; last_error: most recent cause
//   status_byte   : {busy, last_error, error_count[4:0]} for MISO readback
module spi_config_assembler
  import spi_cfg_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter logic [31:0] RESET_CONFIG   = 32'hBBFC_0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        err_clear,
  output logic [31:0] config_out,
  output logic        config_update,
  output logic        busy,
  output logic [7:0]  error_count,
  output logic [1:0]  last_error,
  output logic [7:0]  status_byte
);

  state_t             state_q, state_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [7:0]         xor_acc_q, xor_acc_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [31:0]        config_q, config_d;
  logic               config_update_q, config_update_d;
  logic [7:0]         error_count_q, error_count_d;
  logic [1:0]         last_error_q, last_error_d;
  logic               err_set;
  logic [1:0]         err_cause;
  logic               timeout_expired;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .kick   (byte_valid),
    .expired(timeout_expired)
  );

  always_comb begin
    state_d         = state_q;
    shadow_d        = shadow_q;
    xor_acc_d       = xor_acc_q;
    byte_idx_d      = byte_idx_q;
    config_d        = config_q;
    config_update_d = 1'b0;
    err_set         = 1'b0;
    err_cause       = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (byte_valid && !ss_n && byte_data == HEADER) begin
          state_d    = DATA;
          byte_idx_d = '0;
          xor_acc_d  = '0;
        end
      end
      // Priority inside a frame: chip-select abort, then byte, then timeout.
      DATA: begin
        if (ss_n) begin
          state_d   = IDLE;
          err_set   = 1'b1;
          err_cause = ERR_ABT;
        end else if (byte_valid) begin
          shadow_d   = {shadow_q[23:0], byte_data};
          xor_acc_d  = xor_acc_q ^ byte_data;
          byte_idx_d = byte_idx_q + IDX_W'(1);
          if (byte_idx_q == IDX_W'(FRAME_BYTES - 1)) state_d = CHECK;
        end else if (timeout_expired) begin
          state_d   = IDLE;
          err_set   = 1'b1;
          err_cause = ERR_TMO;
        end
      end
      CHECK: begin
        if (ss_n) begin
          state_d   = IDLE;
          err_set   = 1'b1;
          err_cause = ERR_ABT;
        end else if (byte_valid) begin
          state_d = IDLE;
          if (byte_data == xor_acc_q) begin
            config_d        = shadow_q;
            config_update_d = 1'b1;
          end else begin
            err_set   = 1'b1;
            err_cause = ERR_CHK;
          end
        end else if (timeout_expired) begin
          state_d   = IDLE;
          err_set   = 1'b1;
          err_cause = ERR_TMO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error in the same cycle as err_clear leaves the count at 1.
  always_comb begin
    error_count_d = error_count_q;
    last_error_d  = last_error_q;
    if (err_set) begin
      last_error_d = err_cause;
      if (err_clear)                   error_count_d = 8'd1;
      else if (error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
    end else if (err_clear) begin
      error_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      shadow_q        <= '0;
      xor_acc_q       <= '0;
      byte_idx_q      <= '0;
      config_q        <= RESET_CONFIG;
      config_update_q <= 1'b0;
      error_count_q   <= '0;
      last_error_q    <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      shadow_q        <= shadow_d;
      xor_acc_q       <= xor_acc_d;
      byte_idx_q      <= byte_idx_d;
      config_q        <= config_d;
      config_update_q <= config_update_d;
      error_count_q   <= error_count_d;
      last_error_q    <= last_error_d;
    end
  end

  assign config_out    = config_q;
  assign config_update = config_update_q;
  assign busy          = (state_q != IDLE);
  assign error_count   = error_count_q;
  assign last_error    = last_error_q;
  assign status_byte   = {busy, last_error_q, error_count_q[4:0]};

endmodule

// File: tb/tb_spi_config_assembler.sv
module tb_spi_config_assembler;

  logic        clk;
  logic        rst_n;
  logic        ss_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        err_clear;
  logic [31:0] config_out;
  logic        config_update;
  logic        busy;
  logic [7:0]  error_count;
  logic [1:0]  last_error;
  logic [7:0]  status_byte;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  spi_config_assembler #(
    .HEADER        (8'hA5),
    .RESET_CONFIG  (32'hBBFC_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ss_n         (ss_n),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .err_clear    (err_clear),
    .config_out   (config_out),
    .config_update(config_update),
    .busy         (busy),
    .error_count  (error_count),
    .last_error   (last_error),
    .status_byte  (status_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered and left on a negedge; the byte is captured on the posedge between.
  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(chk);
  endtask

  task automatic abort_frame();
    ss_n = 1'b0;
    send_byte(8'hA5);
    ss_n = 1'b1;
    @(negedge clk);
    ss_n = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ss_n       = 1'b1;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    err_clear  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_config",  config_out, 32'hBBFC_0000);
    check("rst_update",  32'(config_update), 32'd0);
    check("rst_errcnt",  32'(error_count), 32'd0);
    check("rst_lasterr", 32'(last_error), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_status",  32'(status_byte), 32'h00);

    // Valid frame: commit one cycle after CHK, single-cycle pulse
    ss_n = 1'b0;
    send_byte(8'hA5);
    check("hdr_busy", 32'(busy), 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    check("pre_chk_config", config_out, 32'hBBFC_0000);
    send_byte(8'h08);
    check("ok_config", config_out, 32'h1234_5678);
    check("ok_update", 32'(config_update), 32'd1);
    check("ok_busy",   32'(busy), 32'd0);
    idle(1);
    check("ok_update_drop", 32'(config_update), 32'd0);
    check("ok_errcnt",      32'(error_count), 32'd0);

    // Bad checksum
    send_frame(32'h1234_5678, 8'h09);
    check("bad_update",  32'(config_update), 32'd0);
    check("bad_config",  config_out, 32'h1234_5678);
    check("bad_errcnt",  32'(error_count), 32'd1);
    check("bad_lasterr", 32'(last_error), 32'd1);
    check("bad_busy",    32'(busy), 32'd0);
    check("bad_status",  32'(status_byte), 32'h21);

    // Chip-select abort coincident with a byte strobe
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    ss_n = 1'b1;
    send_byte(8'h56);
    check("abt_busy",    32'(busy), 32'd0);
    check("abt_lasterr", 32'(last_error), 32'd3);
    check("abt_errcnt",  32'(error_count), 32'd2);
    check("abt_config",  config_out, 32'h1234_5678);
    // ss_n high in IDLE with traffic: nothing happens
    send_byte(8'hA5);
    check("ssn_idle_busy", 32'(busy), 32'd0);
    ss_n = 1'b0;
    send_frame(32'h0102_0304, 8'h04);
    check("post_abt_config", config_out, 32'h0102_0304);
    check("post_abt_update", 32'(config_update), 32'd1);

    // Timeout: 16 idle cycles after a byte expires the frame
    send_byte(8'hA5);
    send_byte(8'hAA);
    idle(15);
    check("tmo_busy_15", 32'(busy), 32'd1);
    idle(1);
    check("tmo_busy_16", 32'(busy), 32'd0);
    check("tmo_lasterr", 32'(last_error), 32'd2);
    check("tmo_errcnt",  32'(error_count), 32'd3);

    // Late bytes (15th idle cycle, then coincident with expiry) are accepted
    send_byte(8'hA5);
    send_byte(8'hAA);
    idle(14);
    send_byte(8'hBB);
    idle(15);
    send_byte(8'hCC);
    check("late_busy", 32'(busy), 32'd1);
    send_byte(8'hDD);
    send_byte(8'h00);
    check("late_config",  config_out, 32'hAABB_CCDD);
    check("late_errcnt",  32'(error_count), 32'd3);
    check("late_lasterr", 32'(last_error), 32'd2);

    // Non-header bytes in IDLE are ignored
    send_byte(8'h00);
    check("ign00_busy", 32'(busy), 32'd0);
    send_byte(8'hFF);
    check("ignFF_busy",   32'(busy), 32'd0);
    check("ign_errcnt",   32'(error_count), 32'd3);

    // Back-to-back frames
    send_frame(32'h1122_3344, 8'h44);
    check("b2b1_config", config_out, 32'h1122_3344);
    check("b2b1_update", 32'(config_update), 32'd1);
    send_byte(8'hA5);
    check("b2b2_hdr_busy", 32'(busy), 32'd1);
    check("b2b2_hdr_upd",  32'(config_update), 32'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'hCC);
    check("b2b2_config", config_out, 32'h5566_7788);
    check("b2b2_update", 32'(config_update), 32'd1);

    // err_clear coincident with a checksum error, then alone
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    err_clear = 1'b1;
    send_byte(8'h05);
    err_clear = 1'b0;
    check("clr_coinc_errcnt",  32'(error_count), 32'd1);
    check("clr_coinc_lasterr", 32'(last_error), 32'd1);
    check("clr_coinc_config",  config_out, 32'h5566_7788);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check("clr_errcnt",  32'(error_count), 32'd0);
    check("clr_lasterr", 32'(last_error), 32'd1);

    // Saturation
    for (int i = 0; i < 254; i++) abort_frame();
    check("sat_254", 32'(error_count), 32'd254);
    abort_frame();
    check("sat_255", 32'(error_count), 32'd255);
    for (int i = 0; i < 45; i++) abort_frame();
    check("sat_300",       32'(error_count), 32'd255);
    check("sat_lasterr",   32'(last_error), 32'd3);
    check("sat_status",    32'(status_byte), 32'h7F);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check("sat_clr", 32'(error_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
